wb_stream_reader: RTL

Wishbone classic-cycle initiator that fetches a contiguous block of 32-bit words from a Wishbone responder (for example the DFF RAM peripheral) and delivers them in order on a valid/ready stream toward the systolic array.

- A job is a base address and a word count.
- Words are read one at a time, with one transaction outstanding.
- Words are buffered in a small FIFO so that stream back-pressure never stalls a bus transaction mid-cycle.

---
 rtl/wb_stream_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_stream_reader.sv
// Wishbone classic-cycle block reader: fetches count_i words from base_addr_i and streams them out in order.
// Optional ack timeout is enabled by defining WB_STREAM_READER_TIMEOUT_EN.
module wb_stream_reader #(
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 9,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  input  logic [31:0]          wbm_dat_i,
  input  logic                 wbm_ack_i,
  output logic [31:0]          m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_GAP, S_FLUSH, S_DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] remaining;
  logic [31:0]          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fill;
  logic                 fifo_full, fifo_empty;
  logic                 stb, ack_ok, push, pop, timeout;

  assign fifo_full  = (fill == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (fill == '0);

  // Strobe is a pure decode of flops, so an async reset drops it without waiting for an edge.
  assign stb    = (state == S_REQ) && !fifo_full;
  assign ack_ok = stb && wbm_ack_i;
  assign push   = ack_ok;
  assign pop    = !fifo_empty && m_ready_i;

  assign wbm_cyc_o = stb;
  assign wbm_stb_o = stb;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign m_valid_o = !fifo_empty;
  assign m_data_o  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr];

`ifdef WB_STREAM_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign timeout = stb && !wbm_ack_i && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_o   = err_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      wait_cnt <= (stb && !wbm_ack_i) ? wait_cnt + 1'b1 : '0;
      if (state == S_IDLE && start_i) err_q <= 1'b0;
      else if (timeout)               err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // NOTE: the storage array has no reset; only pointers and fill carry state, so an
  // async reset empties the FIFO while the RAM itself stays reset-free.
  always_ff @(posedge wb_clk_i) begin
    if (push) fifo_mem[wr_ptr] <= wbm_dat_i;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      remaining <= '0;
      wbm_adr_o <= 32'h0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (count_i != '0) begin
              wbm_adr_o <= base_addr_i;
              remaining <= count_i;
              busy_o    <= 1'b1;
              state     <= S_REQ;
            end else begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (ack_ok) begin
            wbm_adr_o <= wbm_adr_o + 32'd4;
            remaining <= remaining - 1'b1;
            state     <= S_GAP;
          end else if (timeout) begin
            remaining <= '0;
            state     <= S_FLUSH;
          end
        end
        // One idle cycle swallows the trailing ack of a registered-ack responder.
        S_GAP:   state <= (remaining != '0) ? S_REQ : S_FLUSH;
        S_FLUSH: begin
          if (fifo_empty) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
